// File: rtl/param_alu_pkg.sv
// Shared ALU types and defaults.
//   alu_op_e    : 3-bit opcode (codes 6 and 7 are illegal at the DUT)
//   alu_state_e : control FSM states
package alu_pkg;

    localparam int unsigned ALU_DEF_WIDTH   = 8;
    localparam int unsigned ALU_DEF_MUL_LAT = 3;

    typedef enum logic [2:0] {
        NO_OP  = 3'd0,
        ADD_OP = 3'd1,
        AND_OP = 3'd2,
        XOR_OP = 3'd3,
        MUL_OP = 3'd4,
        SUB_OP = 3'd5,
        RST_OP = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/param_alu_if.sv
// Request/complete handshake bundle for param_alu.
//   master : drives start/op/A/B, observes done/err/busy/result
//   slave  : the ALU side
interface param_alu_if #(
    parameter int unsigned WIDTH = alu_pkg::ALU_DEF_WIDTH
);
    logic                 start;
    logic [2:0]           op;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 done;
    logic                 err;
    logic                 busy;
    logic [2*WIDTH-1:0]   result;

    modport master (output start, op, A, B, input done, err, busy, result);
    modport slave  (input start, op, A, B, output done, err, busy, result);
endinterface

// File: rtl/param_alu_mul_pipe.sv
// MUL_LAT-stage unsigned product pipeline with a valid bit per stage.
//   clk, reset : clock, async active-high clear
//   i_start    : load stage 0 with i_a*i_b
//   i_a, i_b   : operands, sampled with i_start
//   o_valid    : final-stage valid
//   o_prod     : final-stage product (2*WIDTH)
module alu_mul_pipe #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_valid,
    output logic [2*WIDTH-1:0]   o_prod
);
    localparam int unsigned RW = 2 * WIDTH;

    logic [MUL_LAT-1:0] r_vld;
    logic [RW-1:0]      r_prod [MUL_LAT];
    logic [RW-1:0]      w_prod;

    assign w_prod = RW'(i_a) * RW'(i_b);

    // Product enters at the capture edge and advances one stage per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                r_prod[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_start;
            if (i_start) begin
                r_prod[0] <= w_prod;
            end
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_prod[i] <= r_prod[i-1];
            end
        end
    end

    assign o_valid = r_vld[MUL_LAT-1];
    assign o_prod  = r_prod[MUL_LAT-1];

endmodule

// File: rtl/param_alu.sv
// Parametrised multi-cycle ALU with start/done handshake.
//   clk, reset : clock, async active-high clear
//   bus        : param_alu_if slave (start/op/A/B in; done/err/busy/result out)
// Single-cycle ops resolve one edge after capture; mul completes MUL_LAT
// edges after capture. All outputs are registered.
module param_alu import alu_pkg::*; #(
    parameter int unsigned WIDTH   = ALU_DEF_WIDTH,
    parameter int unsigned MUL_LAT = ALU_DEF_MUL_LAT
) (
    input  logic        clk,
    input  logic        reset,
    param_alu_if.slave  bus
);
    localparam int unsigned RW = 2 * WIDTH;

    alu_state_e        r_state;
    alu_state_e        w_state_nxt;
    logic [2:0]        r_op;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_done;
    logic              r_err;
    logic              r_busy;
    logic [RW-1:0]     r_result;

    logic              w_cap;
    logic              w_mul_start;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_busy_nxt;
    logic [RW-1:0]     w_result_nxt;
    logic [RW-1:0]     w_exec_res;
    logic              w_exec_ill;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH:0]    w_diff;
    logic              w_mul_vld;
    logic [RW-1:0]     w_mul_prod;

    alu_mul_pipe #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_mul_start),
        .i_a     (bus.A),
        .i_b     (bus.B),
        .o_valid (w_mul_vld),
        .o_prod  (w_mul_prod)
    );

    // Extra bit keeps the carry/borrow; the borrow bit drives sign extension.
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    // Single-cycle datapath on the captured operands.
    always_comb begin
        w_exec_res = '0;
        w_exec_ill = 1'b0;
        case (r_op)
            ADD_OP:  w_exec_res = {{(WIDTH-1){1'b0}}, w_sum};
            AND_OP:  w_exec_res = {{WIDTH{1'b0}}, r_a & r_b};
            XOR_OP:  w_exec_res = {{WIDTH{1'b0}}, r_a ^ r_b};
            SUB_OP:  w_exec_res = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
            default: w_exec_ill = 1'b1;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_cap        = 1'b0;
        w_mul_start  = 1'b0;
        w_done_nxt   = 1'b0;
        w_err_nxt    = r_err;
        w_busy_nxt   = r_busy;
        w_result_nxt = r_result;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && (bus.op != NO_OP)) begin
                    w_cap      = 1'b1;
                    w_busy_nxt = 1'b1;
                    if (bus.op == MUL_OP) begin
                        w_mul_start = 1'b1;
                        w_state_nxt = ST_MUL;
                    end else begin
                        w_state_nxt = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                w_state_nxt  = ST_IDLE;
                w_done_nxt   = 1'b1;
                w_busy_nxt   = 1'b0;
                w_err_nxt    = w_exec_ill;
                w_result_nxt = w_exec_res;
            end
            ST_MUL: begin
                if (w_mul_vld) begin
                    w_state_nxt  = ST_IDLE;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_err_nxt    = 1'b0;
                    w_result_nxt = w_mul_prod;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_op     <= 3'(NO_OP);
            r_a      <= '0;
            r_b      <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            r_busy   <= w_busy_nxt;
            r_result <= w_result_nxt;
            if (w_cap) begin
                r_op <= bus.op;
                r_a  <= bus.A;
                r_b  <= bus.B;
            end
        end
    end

    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.busy   = r_busy;
    assign bus.result = r_result;

endmodule

// File: tb/tb_param_alu.sv
// Directed bench for param_alu: an 8-bit/MUL_LAT=3 instance and a
// 16-bit/MUL_LAT=1 instance sharing clock and reset.
module tb_param_alu;

    logic clk;
    logic reset;

    param_alu_if #(.WIDTH(8))  if8 ();
    param_alu_if #(.WIDTH(16)) if16 ();

    param_alu #(.WIDTH(8), .MUL_LAT(3)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    param_alu #(.WIDTH(16), .MUL_LAT(1)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs8 [11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input bit s16, input logic st, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b);
        if (s16) begin
            if16.start = st; if16.op = op; if16.A = a; if16.B = b;
        end else begin
            if8.start = st; if8.op = op; if8.A = a[7:0]; if8.B = b[7:0];
        end
    endtask

    function automatic logic get_done(input bit s16);
        return s16 ? if16.done : if8.done;
    endfunction

    function automatic logic get_busy(input bit s16);
        return s16 ? if16.busy : if8.busy;
    endfunction

    function automatic logic get_err(input bit s16);
        return s16 ? if16.err : if8.err;
    endfunction

    function automatic logic [31:0] get_res(input bit s16);
        return s16 ? if16.result : 32'(if8.result);
    endfunction

    // One request; start is dropped at the negedge right after capture.
    task automatic run_op(input bit s16, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] exp_res,
                          input logic exp_err, input int exp_lat, input string name);
        int  n;
        bit  seen;
        @(negedge clk);
        drive(s16, 1'b1, op, a, b);
        @(negedge clk);
        drive(s16, 1'b0, op, a, b);
        check({name, " busy_after_capture"}, 32'(get_busy(s16)), 32'd1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (get_done(s16)) seen = 1'b1;
        end
        check({name, " latency"}, 32'(n), 32'(exp_lat));
        check({name, " result"}, get_res(s16), exp_res);
        check({name, " err"}, 32'(get_err(s16)), 32'(exp_err));
        check({name, " busy_at_done"}, 32'(get_busy(s16)), 32'd0);
        @(negedge clk);
        check({name, " done_one_cycle"}, 32'(get_done(s16)), 32'd0);
    endtask

    initial begin
        int dcnt;
        logic [4:0] dpat;

        vecs8[0]  = '{3'd1, 16'h00FF, 16'h0001, 32'h0000_0100, 1'b0, 1};
        vecs8[1]  = '{3'd1, 16'h007F, 16'h0001, 32'h0000_0080, 1'b0, 1};
        vecs8[2]  = '{3'd2, 16'h00F0, 16'h003C, 32'h0000_0030, 1'b0, 1};
        vecs8[3]  = '{3'd3, 16'h00F0, 16'h003C, 32'h0000_00CC, 1'b0, 1};
        vecs8[4]  = '{3'd5, 16'h0001, 16'h0002, 32'h0000_FFFF, 1'b0, 1};
        vecs8[5]  = '{3'd5, 16'h0005, 16'h0003, 32'h0000_0002, 1'b0, 1};
        vecs8[6]  = '{3'd4, 16'h00FF, 16'h00FF, 32'h0000_FE01, 1'b0, 3};
        vecs8[7]  = '{3'd4, 16'h000C, 16'h000A, 32'h0000_0078, 1'b0, 3};
        vecs8[8]  = '{3'd6, 16'h0012, 16'h0034, 32'h0000_0000, 1'b1, 1};
        vecs8[9]  = '{3'd7, 16'h00AA, 16'h0055, 32'h0000_0000, 1'b1, 1};
        vecs8[10] = '{3'd1, 16'h0000, 16'h0000, 32'h0000_0000, 1'b0, 1};

        reset = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 3'd0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        check("reset done",   32'(if8.done), 32'd0);
        check("reset err",    32'(if8.err),  32'd0);
        check("reset busy",   32'(if8.busy), 32'd0);
        check("reset result", get_res(1'b0), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op(1'b0, vecs8[i].op, vecs8[i].a, vecs8[i].b, vecs8[i].res,
                   vecs8[i].err, vecs8[i].lat, $sformatf("vec%0d", i));
        end

        // start held across done relaunches an add two cycles later.
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd1, 16'h0001, 16'h0002);
        dpat = '0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            dpat[n] = if8.done;
            if (n == 2) drive(1'b0, 1'b0, 3'd1, 16'h0001, 16'h0002);
        end
        check("b2b done_pattern", 32'(dpat), 32'b01010);
        check("b2b result", get_res(1'b0), 32'h0003);

        // mul with inputs changed (and a stray start) while busy.
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd4, 16'h00FF, 16'h00FF);
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd1, 16'h0000, 16'h0000);
        check("mulhold busy_k", 32'(if8.busy), 32'd1);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd1, 16'h0000, 16'h0000);
        check("mulhold busy_k1", 32'(if8.busy), 32'd1);
        check("mulhold no_early_done", 32'(if8.done), 32'd0);
        @(negedge clk);
        check("mulhold busy_k2", 32'(if8.busy), 32'd1);
        @(negedge clk);
        check("mulhold done_k3", 32'(if8.done), 32'd1);
        check("mulhold busy_k3", 32'(if8.busy), 32'd0);
        check("mulhold result", get_res(1'b0), 32'h0000_FE01);
        @(negedge clk);
        check("mulhold single_done", 32'(if8.done), 32'd0);

        // Reset asserted one edge into a mul aborts it.
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd4, 16'h000F, 16'h000F);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort busy",   32'(if8.busy), 32'd0);
        check("abort done",   32'(if8.done), 32'd0);
        check("abort result", get_res(1'b0), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (if8.done) dcnt++;
        end
        check("abort no_done", 32'(dcnt), 32'd0);
        check("abort result_after", get_res(1'b0), 32'd0);
        run_op(1'b0, 3'd1, 16'h0002, 16'h0003, 32'h0005, 1'b0, 1, "post_reset_add");

        // Illegal opcode followed by a no_op request.
        run_op(1'b0, 3'd6, 16'h0011, 16'h0022, 32'h0000, 1'b1, 1, "ill6");
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd0, 16'h0055, 16'h0066);
        dcnt = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (n == 0) drive(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
            if (if8.done || if8.busy) dcnt++;
        end
        check("noop no_done_no_busy", 32'(dcnt), 32'd0);
        check("noop err_holds", 32'(if8.err), 32'd1);

        // 16-bit, single-cycle multiply instance.
        run_op(1'b1, 3'd4, 16'hFFFF, 16'h0002, 32'h0001_FFFE, 1'b0, 1, "w16 mul");
        run_op(1'b1, 3'd1, 16'hFFFF, 16'hFFFF, 32'h0001_FFFE, 1'b0, 1, "w16 add");
        run_op(1'b1, 3'd5, 16'h0000, 16'h0001, 32'hFFFF_FFFF, 1'b0, 1, "w16 sub");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_alu.md
# param_alu

Parametrised successor to the fixed 8-bit TinyALU DUT. It keeps the start/done handshake of that ALU but makes operand width and multiplier latency parameters, adds a subtract op, and adds `busy` and `err` status outputs. It sits as the DUT behind the ALU BFM and driver in the UVM bench, and is reusable wherever a multi-cycle arithmetic unit with a request/complete handshake is needed.

## Interface
- `WIDTH`, default 8: operand width in bits, minimum 2.
- `MUL_LAT`, default 3: multiply latency in cycles from capture to `done`, minimum 1.
- `clk` in 1: single clock; all state updates on the posedge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: request; sampled on the posedge while idle.
- `op` in 3: `alu_op_e` opcode; captured with `start`.
- `A` in WIDTH: operand A, unsigned; captured with `start`.
- `B` in WIDTH: operand B, unsigned; captured with `start`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: high with `done` when the captured opcode is illegal; holds until the next `done`.
- `busy` out 1: an operation is in flight.
- `result` out 2*WIDTH: registered result; holds until the next `done`.

## Operation
- Opcodes are `no_op`=0, `add_op`=1, `and_op`=2, `xor_op`=3, `mul_op`=4, `sub_op`=5. Codes 6 and 7 are illegal. Code 7 is `rst_op`, which is bench-only.
- FSM states:
  - IDLE: waiting for a request.
  - EXEC: single-cycle ops and illegal opcodes.
  - MUL: counting `MUL_LAT` cycles.
- IDLE:
  - `start`=1 with `op`=`no_op` causes no capture, no `done`, and the FSM stays in IDLE.
  - `start`=1 with any other `op` captures `op`, `A` and `B`. The FSM then goes to MUL if `op`=`mul_op`, otherwise to EXEC.
- EXEC always returns to IDLE on the next posedge and produces `done`.
- MUL returns to IDLE and produces `done` once its count reaches `MUL_LAT`.
- Result arithmetic, with all results 2*WIDTH wide:
  - add: zero-extended sum; the carry lands in bit WIDTH.
  - and, xor: zero-extended.
  - sub: A−B as two's complement, sign-extended to 2*WIDTH.
  - mul: full unsigned product.
  - illegal opcode: `result`=0 and `err`=1.
- `start`, `op`, `A` and `B` are ignored while `busy`=1. Captured values are not affected by input changes.
- `start` still high in the IDLE cycle after `done` launches a new operation. The driver must drop `start` at the negedge where it observes `done` unless it intends to re-issue.
- Reset values: state IDLE, `done`=0, `err`=0, `busy`=0, `result`=0, multiply pipeline cleared.
- Reset asserted mid-operation aborts the operation: no `done` is produced, and `result` reads 0.

## Timing
- Let posedge k be the capture edge.
- EXEC ops:
  - `result`, `err` and `done` become valid after posedge k+1.
  - `busy`=1 only during cycle k→k+1.
- mul:
  - `done` and `result` become valid after posedge k+MUL_LAT.
  - `busy`=1 from posedge k until posedge k+MUL_LAT, where it falls in the same edge that raises `done`.
- `done` is high for exactly one cycle. The earliest next capture is posedge k+L+1, where L is the op latency, giving back-to-back throughput of one op per L+1 cycles.
- All outputs are registered, so there is no combinational path from any input to any output.

## Structure
- `alu_pkg` holds:
  - the `alu_op_e` enum, 3 bits;
  - `ALU_DEF_WIDTH`=8 and `ALU_DEF_MUL_LAT`=3.
- `tb_pkg` imports `alu_pkg` so the transaction and BFM share the opcode type.
- Sub-module `alu_mul_pipe`, parametrised by `WIDTH` and `MUL_LAT`:
  - a `MUL_LAT`-stage product pipeline with a valid bit per stage;
  - its final valid bit drives the MUL→IDLE transition;
  - cleared by `reset`.

## Test plan
- WIDTH=8, add A=8'hFF B=8'h01 → `result`=16'h0100, `done` 1 cycle after capture, `err`=0.
- WIDTH=8, MUL_LAT=3, mul A=8'hFF B=8'hFF → `result`=16'hFE01, `done` at k+3, `busy` high k..k+3; A/B changed at k+1 do not affect the result.
- sub A=8'h01 B=8'h02 → `result`=16'hFFFF. xor A=8'hF0 B=8'h3C → `result`=16'h00CC.
- `reset` pulsed at k+1 of a mul → `busy`/`done`/`result` go to 0 immediately. No `done` follows, and a fresh add after release completes normally.
- op=3'b110 → `done` at k+1 with `err`=1 and `result`=0. A following `start` with `no_op` gives no `done` and `busy` stays 0.
- WIDTH=16, MUL_LAT=1, mul A=16'hFFFF B=16'h0002 → `result`=32'h0001FFFE at k+1.
